// File: rtl/sample_capture_buffer.sv
// Trigger-aware capture buffer: linear post-trigger or circular pre-trigger
// storage in a 2**ADDR_W RAM, drained oldest-first through a registered port.
module sample_capture_buffer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              arm,
    input  logic              mode,
    input  logic [ADDR_W:0]   post_count,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              trigger,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              triggered,
    output logic              done,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic [ADDR_W-1:0] trig_index
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_POST,
        S_DONE
    } state_e;

    localparam logic [ADDR_W:0]   DEPTH_C  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   DEPTH_M1 = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0]   C_ONE    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] A_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem [2**ADDR_W];

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic [ADDR_W:0]   post_q, post_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   stored_q, stored_d;
    logic [ADDR_W:0]   remain_q, remain_d;
    logic              triggered_q, triggered_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   unread_q, unread_d;
    logic [ADDR_W-1:0] trig_index_q, trig_index_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q;

    logic arm_ok;
    logic trig_acc;
    logic we;
    logic rd_fire;
    logic enter_done;

    assign arm_ok   = !clear && arm
                   && (state_q == S_IDLE || state_q == S_DONE);
    assign trig_acc = !clear && state_q == S_ARMED
                   && trigger && sample_en;
    // Linear mode only writes once the trigger sample arrives.
    assign we       = !clear && sample_en
                   && ((state_q == S_ARMED && (mode_q || trigger))
                   || state_q == S_POST);
    assign rd_fire  = !clear && !arm && state_q == S_DONE
                   && rd_req && unread_q != '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            mode_q       <= 1'b0;
            post_q       <= '0;
            wr_ptr_q     <= '0;
            stored_q     <= '0;
            remain_q     <= '0;
            triggered_q  <= 1'b0;
            trig_addr_q  <= '0;
            rd_ptr_q     <= '0;
            unread_q     <= '0;
            trig_index_q <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            post_q       <= post_d;
            wr_ptr_q     <= wr_ptr_d;
            stored_q     <= stored_d;
            remain_q     <= remain_d;
            triggered_q  <= triggered_d;
            trig_addr_q  <= trig_addr_d;
            rd_ptr_q     <= rd_ptr_d;
            unread_q     <= unread_d;
            trig_index_q <= trig_index_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_ptr_q] <= sample_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else if (rd_fire) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (arm) state_d = S_ARMED;
                end
                S_ARMED: begin
                    if (trig_acc) begin
                        if (mode_q) begin
                            state_d = (post_q == '0) ? S_DONE : S_POST;
                        end else begin
                            state_d = (stored_q == DEPTH_M1) ? S_DONE : S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (sample_en) begin
                        if (mode_q ? (remain_q == C_ONE)
                                   : (stored_q == DEPTH_M1)) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (arm) state_d = S_ARMED;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign enter_done = state_q != S_DONE && state_d == S_DONE;

    always_comb begin
        mode_d       = mode_q;
        post_d       = post_q;
        wr_ptr_d     = wr_ptr_q;
        stored_d     = stored_q;
        remain_d     = remain_q;
        triggered_d  = triggered_q;
        trig_addr_d  = trig_addr_q;
        rd_ptr_d     = rd_ptr_q;
        unread_d     = unread_q;
        trig_index_d = trig_index_q;
        rd_valid_d   = 1'b0;
        if (clear) begin
            mode_d       = 1'b0;
            post_d       = '0;
            wr_ptr_d     = '0;
            stored_d     = '0;
            remain_d     = '0;
            triggered_d  = 1'b0;
            trig_addr_d  = '0;
            rd_ptr_d     = '0;
            unread_d     = '0;
            trig_index_d = '0;
        end else begin
            if (arm_ok) begin
                mode_d       = mode;
                post_d       = (post_count > DEPTH_M1) ? DEPTH_M1 : post_count;
                wr_ptr_d     = '0;
                stored_d     = '0;
                remain_d     = '0;
                triggered_d  = 1'b0;
                trig_addr_d  = '0;
                rd_ptr_d     = '0;
                unread_d     = '0;
                trig_index_d = '0;
            end
            if (we) begin
                wr_ptr_d = wr_ptr_q + A_ONE;
                stored_d = (stored_q == DEPTH_C) ? stored_q : stored_q + C_ONE;
            end
            if (trig_acc) begin
                triggered_d = 1'b1;
                trig_addr_d = wr_ptr_q;
                remain_d    = post_q;
            end else if (state_q == S_POST && we && remain_q != '0) begin
                remain_d = remain_q - C_ONE;
            end
            // Oldest sample sits just past the last write once the ring is full.
            if (enter_done) begin
                rd_ptr_d     = (stored_d == DEPTH_C) ? wr_ptr_d : '0;
                unread_d     = stored_d;
                trig_index_d = trig_addr_d - rd_ptr_d;
            end
            if (rd_fire) begin
                rd_ptr_d   = rd_ptr_q + A_ONE;
                unread_d   = unread_q - C_ONE;
                rd_valid_d = 1'b1;
            end
        end
    end

    always_comb begin
        busy       = state_q == S_ARMED || state_q == S_POST;
        done       = state_q == S_DONE;
        empty      = done && unread_q == '0;
        level      = busy ? stored_q : (done ? unread_q : '0);
        triggered  = triggered_q;
        trig_index = trig_index_q;
        rd_valid   = rd_valid_q;
        rd_data    = rd_data_q;
    end

endmodule

// File: tb/tb_sample_capture_buffer.sv
// Randomised capture/readout bench for sample_capture_buffer with a
// queue-based reference model and a decoupled readout scoreboard.
module tb_sample_capture_buffer;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clear;
    logic          arm;
    logic          mode;
    logic [AW:0]   post_count;
    logic          sample_en;
    logic [DW-1:0] sample_in;
    logic          trigger;
    logic          rd_req;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          busy;
    logic          triggered;
    logic          done;
    logic          empty;
    logic [AW:0]   level;
    logic [AW-1:0] trig_index;

    int vec = 0;
    int mis = 0;
    logic [DW-1:0] sb[$];

    sample_capture_buffer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .arm        (arm),
        .mode       (mode),
        .post_count (post_count),
        .sample_en  (sample_en),
        .sample_in  (sample_in),
        .trigger    (trigger),
        .rd_req     (rd_req),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .triggered  (triggered),
        .done       (done),
        .empty      (empty),
        .level      (level),
        .trig_index (trig_index)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every rd_valid pulse consumes one expected sample.
    always @(negedge clk) begin
        if (reset_n && rd_valid) begin
            if (sb.size() == 0) begin
                vec++;
                mis++;
                $display("FAIL rd_valid_extra: got pulse data %0d, expected no pulse",
                         rd_data);
            end else begin
                chk("rd_data", 32'(rd_data), 32'(sb.pop_front()));
            end
        end
    end

    // status: 0 capture done, 1 stopped in POST on request, 2 timeout
    task automatic capture(input bit m, input int post, input int pre_n,
                           input int abort_after, output int status,
                           output int nkept);
        logic [DW-1:0] w[$];
        bit trig = 0;
        bit mdone = 0;
        bit se;
        bit tr;
        logic [DW-1:0] d;
        int remain = 0;
        int tpos = 0;
        int nen = 0;
        int posts = 0;
        int cyc = 0;
        int pc;
        int cap;
        pc = (post > DEPTH - 1) ? DEPTH - 1 : post;
        status = 0;
        nkept = 0;
        arm = 1'b1;
        mode = m;
        post_count = post[AW:0];
        @(posedge clk); #1;
        arm = 1'b0;
        forever begin
            cap = (w.size() > DEPTH) ? DEPTH : w.size();
            chk("busy", 32'(busy), 32'(!mdone));
            chk("done", 32'(done), 32'(mdone));
            chk("triggered", 32'(triggered), 32'(trig));
            chk("level_cap", 32'(level), 32'(cap));
            if (mdone) break;
            if (trig && posts == abort_after) begin
                status = 1;
                break;
            end
            if (cyc++ > 3000) begin
                vec++;
                mis++;
                $display("FAIL capture_timeout: got no done after %0d cycles, expected done",
                         cyc);
                status = 2;
                break;
            end
            se = $urandom_range(0, 3) != 0;
            d = DW'($urandom);
            tr = 1'b0;
            if (se && nen == pre_n) tr = 1'b1;
            else if (!se) tr = $urandom_range(0, 1) == 1;
            else if (nen > pre_n) tr = $urandom_range(0, 3) == 0;
            sample_en = se;
            sample_in = d;
            trigger = tr;
            if (se) begin
                if (!trig && tr) begin
                    trig = 1;
                    w.push_back(d);
                    tpos = w.size() - 1;
                    remain = pc;
                    if (m ? (pc == 0) : (w.size() == DEPTH)) mdone = 1;
                end else if (trig) begin
                    w.push_back(d);
                    posts++;
                    if (m) begin
                        remain--;
                        if (remain == 0) mdone = 1;
                    end else if (w.size() == DEPTH) begin
                        mdone = 1;
                    end
                end else if (m) begin
                    w.push_back(d);
                end
                nen++;
            end
            @(posedge clk); #1;
        end
        sample_en = 1'b0;
        trigger = 1'b0;
        if (status == 0) begin
            while (w.size() > DEPTH) begin
                void'(w.pop_front());
                tpos--;
            end
            chk("trig_index", 32'(trig_index), 32'(tpos));
            chk("empty_full", 32'(empty), 32'(w.size() == 0));
            nkept = w.size();
            foreach (w[i]) sb.push_back(w[i]);
        end
    endtask

    task automatic readout(input int n, input int limit);
        int got = 0;
        int cyc = 0;
        bit rq;
        while (got < limit && cyc < 1000) begin
            rq = $urandom_range(0, 3) != 0;
            rd_req = rq;
            if (rq) got++;
            @(posedge clk); #1;
            cyc++;
            chk("level_rd", 32'(level), 32'(n - got));
        end
        rd_req = 1'b0;
        chk("rd_issued", 32'(got), 32'(limit));
    endtask

    task automatic finish_readout();
        rd_req = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rd_req = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("empty_end", 32'(empty), 32'd1);
        chk("level_end", 32'(level), 32'd0);
        chk("done_end", 32'(done), 32'd1);
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int nk;
        bit    tm[7];
        int    tp[7];
        int    tpre[7];
        tm   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tp   = '{0, 3, 3, 20, 0, 0, 7};
        tpre = '{5, 30, 2, 7, 25, 0, 0};
        tpre[6] = int'($urandom_range(0, 40));
        reset_n = 1'b0;
        clear = 1'b0;
        arm = 1'b0;
        mode = 1'b0;
        post_count = '0;
        sample_en = 1'b0;
        sample_in = '0;
        trigger = 1'b0;
        rd_req = 1'b0;
        #12;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_empty", 32'(empty), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_trig", 32'(triggered), 32'd0);
        chk("rst_tidx", 32'(trig_index), 32'd0);
        chk("rst_rdata", 32'(rd_data), 32'd0);
        rd_req = 1'b1;
        @(posedge clk); #1;
        rd_req = 1'b0;
        chk("idle_rd", 32'(rd_valid), 32'd0);

        for (int t = 0; t < 7; t++) begin
            capture(tm[t], tp[t], tpre[t], -1, st, nk);
            if (st == 0) begin
                readout(nk, nk);
                finish_readout();
            end
        end

        capture(1'b1, 10, 4, 2, st, nk);
        chk("abort_status", 32'(st), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_trig", 32'(triggered), 32'd0);
        @(posedge clk); #3;
        reset_n = 1'b1;
        @(posedge clk); #1;

        capture(1'b0, 0, 3, -1, st, nk);
        if (st == 0) begin
            readout(nk, 4);
            rd_req = 1'b1;
            @(posedge clk); #1;
            rd_req = 1'b0;
            chk("rd_pulse", 32'(rd_valid), 32'd1);
            #2 reset_n = 1'b0;
            #1;
            chk("rst_rd_valid", 32'(rd_valid), 32'd0);
            chk("rst_rd_done", 32'(done), 32'd0);
            sb.delete();
            @(posedge clk); #3;
            reset_n = 1'b1;
            @(posedge clk); #1;
        end

        capture(1'b1, 5, 20, -1, st, nk);
        if (st == 0) begin
            readout(nk, 5);
            clear = 1'b1;
            rd_req = 1'b1;
            @(posedge clk); #1;
            clear = 1'b0;
            rd_req = 1'b0;
            chk("clr_done", 32'(done), 32'd0);
            chk("clr_busy", 32'(busy), 32'd0);
            chk("clr_level", 32'(level), 32'd0);
            chk("clr_rd_valid", 32'(rd_valid), 32'd0);
            chk("clr_trig", 32'(triggered), 32'd0);
            chk("clr_sb_left", 32'(sb.size()), 32'(nk - 5));
            sb.delete();
        end

        capture(1'b0, 0, 9, -1, st, nk);
        if (st == 0) begin
            readout(nk, nk);
            finish_readout();
        end
        capture(1'b1, 3, 30, -1, st, nk);
        if (st == 0) begin
            readout(nk, nk);
            finish_readout();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule

// File: doc/sample_capture_buffer.md
Name: sample_capture_buffer

Overview:
Parametrised trigger-aware sample buffer for the logic analyzer capture path. It replaces the fixed 32K x 8 linear FIFO. It stores DATA_W-bit samples into a 2**ADDR_W-deep synchronous RAM in one of two modes:
- post-trigger linear
- pre-trigger circular (ring buffer with configurable post-trigger count)

After capture completes, the host drains the samples oldest-first through a registered read port.

Parameters:
DATA_W, 8, sample width in bits
ADDR_W, 15, RAM address width; DEPTH = 2**ADDR_W samples

Ports:
clk  in  1  capture/read clock
reset_n  in  1  asynchronous active-low reset
clear  in  1  synchronous abort; returns to IDLE
arm  in  1  start capture (accepted in IDLE or DONE)
mode  in  1  0 = linear post-trigger, 1 = circular pre-trigger; latched on accepted arm
post_count  in  ADDR_W+1  samples stored after trigger sample (mode 1); latched on arm
sample_en  in  1  sample strobe
sample_in  in  DATA_W  sample data
trigger  in  1  trigger event, qualified by sample_en
rd_req  in  1  readout request
rd_data  out  DATA_W  readout data
rd_valid  out  1  rd_data valid (1-cycle pulse)
busy  out  1  state is ARMED or POST
triggered  out  1  trigger accepted in current capture
done  out  1  state is DONE
empty  out  1  DONE and no unread samples
level  out  ADDR_W+1  stored count while capturing; unread count in DONE
trig_index  out  ADDR_W  readout position of trigger sample

Behaviour:
Clock and reset
- One clock; reset is asynchronous and active-low.
- Reset: state=IDLE; all outputs 0; pointers and counters 0. RAM contents are not cleared.
- Reset mid-capture or mid-readout aborts immediately.

clear and arm
- clear has priority over all other inputs except reset. It returns to IDLE and zeroes pointers, counters and flags; rd_valid=0 next cycle.
- arm is accepted in IDLE or DONE:
  - wr_ptr=0, stored=0, triggered=0
  - latch mode
  - latch post_count, clamped to DEPTH-1
  - go to ARMED
- arm in ARMED or POST is ignored.

Trigger acceptance
- A trigger is accepted only when trigger & sample_en are both high in ARMED.

Mode 0 (linear)
- ARMED: samples are discarded until a trigger is accepted.
- The trigger sample is written at address 0.
- Go to POST; each further sample_en writes at wr_ptr+1.
- When stored reaches DEPTH, go to DONE.
- trig_index = 0.

Mode 1 (circular)
- ARMED: every sample_en writes at wr_ptr, which wraps modulo DEPTH. stored saturates at DEPTH.
- On an accepted trigger, the trigger sample is written and the remaining count is set to the latched post_count:
  - post_count=0: go directly to DONE.
  - otherwise: go to POST, write the remaining samples, and go to DONE when remaining reaches 0.
- Post-trigger writes may overwrite the oldest pre-trigger data.

Counters and flags
- stored increments on each write, saturating at DEPTH.
- triggered is set on trigger acceptance and held until arm, clear or reset.
- level = stored during ARMED and POST.

DONE entry
- rd_ptr = oldest sample: wr_ptr_next if stored==DEPTH after wrap, else 0.
- unread = stored.
- trig_index = (trigger address − oldest address) mod DEPTH.

Readout (DONE only)
- rd_req with unread>0: RAM read at rd_ptr; rd_data is registered and rd_valid=1 exactly one cycle later. rd_ptr increments with wrap; unread decrements.
- rd_req with unread=0, or outside DONE: ignored, no rd_valid.
- Back-to-back rd_req gives one sample per cycle.
- rd_data holds its last value between pulses.
- level = unread in DONE; empty = (unread==0) in DONE.

Other rules
- No writes occur in IDLE or DONE; sample_en is ignored there.
- sample_en and trigger are ignored in POST except for counting writes; re-triggers have no effect.
- All pointer arithmetic is modulo DEPTH; counters are ADDR_W+1 bits.

Test Plan:
1. ADDR_W=4, mode 0: arm; feed values 0..40 on consecutive sample_en, trigger at value 5 → done after value 20; readout gives 5..20, trig_index=0, then empty=1; an extra rd_req produces no rd_valid.
2. ADDR_W=4, mode 1, post_count=3: feed 0..39, trigger at 30 → done after 33; readout 18..33 in order, trig_index=12, level starts at 16.
3. ADDR_W=4, mode 1, post_count=3: trigger at value 2 (no wrap) → readout 0..5, level=6, trig_index=2.
4. trigger=1 with sample_en=0 in ARMED → not accepted, triggered stays 0; the next trigger with sample_en=1 is accepted and its sample appears at trig_index.
5. post_count=20 with ADDR_W=4 → clamped to 15: 15 post samples stored, trig_index=0. post_count=0 → DONE the cycle after the trigger, trig_index=15.
6. reset_n low mid-POST → busy, triggered and rd_valid drop immediately; clear during a DONE readout → IDLE next cycle; a subsequent arm runs a full capture correctly.
